core_mem_arb: RTL and testbench

Arbiter and sequencer that shares the core's single memory port between the IFU instruction-fetch requester and the LSU data requester. Each requester uses a valid/ready request channel and a valid/ready response channel, matching the stage-to-stage pipeline handshakes. At most one transaction is outstanding. LSU has fixed priority, and a starvation guard ensures IFU forward progress.

---
 rtl/core_mem_arb.sv | 186 ++++++++++++++++++
 tb/tb_core_mem_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arb.sv
// core_mem_arb: shares the core's single memory port between IFU fetches and LSU loads/stores.
// Latency: accept at T, mem_req_valid at T+1, earliest response beat T+2, idle again at T+3.
// Backpressure: one transaction in flight; both req_ready low while busy, mem_rsp_ready follows the owner's rsp_ready.
module core_mem_arb #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rstn,
  // IFU request / response
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_rsp_valid,
  input  logic        ifu_rsp_ready,
  output logic [31:0] ifu_rsp_data,
  // LSU request / response
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_we,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wstrb,
  output logic        lsu_rsp_valid,
  input  logic        lsu_rsp_ready,
  output logic [31:0] lsu_rsp_data,
  // Memory port
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rsp_data,
  // Current owner: 0 = IFU, 1 = LSU
  output logic        arb_owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic             OWN_IFU    = 1'b0;
  localparam logic             OWN_LSU    = 1'b1;

  state_t            state_q,         state_d;
  logic [CNT_W-1:0]  starve_cnt_q,    starve_cnt_d;
  logic              owner_q,         owner_d;
  logic [31:0]       addr_q,          addr_d;
  logic              we_q,            we_d;
  logic [31:0]       wdata_q,         wdata_d;
  logic [3:0]        wstrb_q,         wstrb_d;
  logic              mem_req_valid_q, mem_req_valid_d;

  logic idle;
  logic ifu_win;
  logic lsu_win;
  logic ifu_acc;
  logic lsu_acc;
  logic in_rsp;
  logic owner_rsp_ready;

  // Fixed LSU priority, except IFU wins once the LSU has taken STARVE_LIMIT grants in a row over it
  always_comb begin
    idle          = (state_q == S_IDLE);
    ifu_win       = ifu_req_valid && (!lsu_req_valid || (starve_cnt_q == STARVE_MAX));
    lsu_win       = lsu_req_valid && !ifu_win;
    ifu_acc       = idle && ifu_win;
    lsu_acc       = idle && lsu_win;
    ifu_req_ready = ifu_acc;
    lsu_req_ready = lsu_acc;
  end

  // Response routing: only the owner sees the memory response, and only in the response phase
  always_comb begin
    in_rsp          = (state_q == S_RSP);
    owner_rsp_ready = (owner_q == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
    mem_rsp_ready   = in_rsp && owner_rsp_ready;
    ifu_rsp_valid   = 1'b0;
    ifu_rsp_data    = '0;
    lsu_rsp_valid   = 1'b0;
    lsu_rsp_data    = '0;
    if (in_rsp) begin
      if (owner_q == OWN_LSU) begin
        lsu_rsp_valid = mem_rsp_valid;
        lsu_rsp_data  = mem_rsp_data;
      end else begin
        ifu_rsp_valid = mem_rsp_valid;
        ifu_rsp_data  = mem_rsp_data;
      end
    end
  end

  // Sequencer next state: capture on accept, hold fields until memory takes them, wait for owner's response
  always_comb begin
    state_d         = state_q;
    starve_cnt_d    = starve_cnt_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    mem_req_valid_d = mem_req_valid_q;
    case (state_q)
      S_IDLE: begin
        if (ifu_acc) begin
          // Fetches are always reads; write fields are zeroed so the port never sees stale store data
          state_d         = S_REQ;
          mem_req_valid_d = 1'b1;
          owner_d         = OWN_IFU;
          addr_d          = ifu_req_addr;
          we_d            = 1'b0;
          wdata_d         = '0;
          wstrb_d         = '0;
          starve_cnt_d    = '0;
        end else if (lsu_acc) begin
          state_d         = S_REQ;
          mem_req_valid_d = 1'b1;
          owner_d         = OWN_LSU;
          addr_d          = lsu_req_addr;
          we_d            = lsu_req_we;
          wdata_d         = lsu_req_wdata;
          wstrb_d         = lsu_req_wstrb;
          // Only grants that actually made the IFU wait count towards starvation
          if (ifu_req_valid && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d         = S_RSP;
          mem_req_valid_d = 1'b0;
        end
      end
      S_RSP: begin
        if (mem_rsp_valid && owner_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d         = S_IDLE;
        mem_req_valid_d = 1'b0;
      end
    endcase
  end

  // State and capture registers; reset abandons any in-flight transaction without a response
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q         <= S_IDLE;
      starve_cnt_q    <= '0;
      owner_q         <= OWN_IFU;
      addr_q          <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      mem_req_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      starve_cnt_q    <= starve_cnt_d;
      owner_q         <= owner_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      mem_req_valid_q <= mem_req_valid_d;
    end
  end

  // Memory request fields come straight from the capture registers so they stay stable under backpressure
  always_comb begin
    mem_req_valid = mem_req_valid_q;
    mem_req_addr  = addr_q;
    mem_req_we    = we_q;
    mem_req_wdata = wdata_q;
    mem_req_wstrb = wstrb_q;
    arb_owner     = owner_q;
  end

endmodule

// File: tb/tb_core_mem_arb.sv
// tb_core_mem_arb: directed walk through the main scenarios, then randomized traffic vs a transaction-level model.
// Inputs change 1 time unit after posedge; outputs are checked on negedge.
// Requesters hold valid until ready (with optional legal withdrawals); memory stalls and response backpressure are randomized.
module tb_core_mem_arb;

  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk;
  logic        rstn;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_we;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_rsp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_rsp_data;
  logic        arb_owner;

  core_mem_arb #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_we(lsu_req_we), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .arb_owner(arb_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // Transaction-level reference: at most one outstanding transaction with its captured request
  logic        m_busy, m_issued, m_own;
  int          m_starve;
  logic [31:0] c_addr, c_wdata;
  logic        c_we;
  logic [3:0]  c_wstrb;
  logic        m_ifu_acc, m_lsu_acc;
  logic        m_track;
  int          lsu_run;
  // Memory slave in the bench
  logic        s_pend;
  logic [31:0] s_data;
  // Randomization knobs (percent; p_rst in per-mille)
  int unsigned p_ifu, p_lsu, p_drop, p_mrdy, p_rv, p_rr, p_rst;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    logic e_ifu_rdy, e_lsu_rdy, e_rsp, e_orr, e_reqv;
    tick();
    rstn = (p_rst != 0) && ($urandom_range(0, 999) < p_rst);
    if (rstn) begin
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
    end else begin
      if (ifu_req_valid && !m_ifu_acc) begin
        if ($urandom_range(0, 99) < p_drop) ifu_req_valid = 1'b0;
      end else begin
        ifu_req_valid = ($urandom_range(0, 99) < p_ifu);
        ifu_req_addr  = $urandom & 32'hFFFF_FFFC;
      end
      if (lsu_req_valid && !m_lsu_acc) begin
        if ($urandom_range(0, 99) < p_drop) lsu_req_valid = 1'b0;
      end else begin
        lsu_req_valid = ($urandom_range(0, 99) < p_lsu);
        lsu_req_addr  = $urandom;
        lsu_req_we    = ($urandom_range(0, 1) == 1);
        lsu_req_wdata = $urandom;
        lsu_req_wstrb = 4'($urandom_range(0, 15));
      end
    end
    mem_req_ready = ($urandom_range(0, 99) < p_mrdy);
    if (s_pend) begin
      mem_rsp_valid = ($urandom_range(0, 99) < p_rv);
      mem_rsp_data  = s_data;
    end else begin
      mem_rsp_valid = ($urandom_range(0, 99) < 10);
      mem_rsp_data  = $urandom;
    end
    ifu_rsp_ready = ($urandom_range(0, 99) < p_rr);
    lsu_rsp_ready = ($urandom_range(0, 99) < p_rr);

    @(negedge clk);
    e_ifu_rdy = !m_busy && ifu_req_valid && (!lsu_req_valid || (m_starve == STARVE_LIMIT));
    e_lsu_rdy = !m_busy && lsu_req_valid && !e_ifu_rdy;
    e_reqv    = m_busy && !m_issued;
    e_rsp     = m_busy && m_issued;
    e_orr     = m_own ? lsu_rsp_ready : ifu_rsp_ready;
    chk_eq("ifu_req_ready", ifu_req_ready, e_ifu_rdy);
    chk_eq("lsu_req_ready", lsu_req_ready, e_lsu_rdy);
    chk_eq("mem_req_valid", mem_req_valid, e_reqv);
    chk_eq("arb_owner", arb_owner, m_own);
    if (e_reqv) begin
      chk_eq("mem_req_addr", mem_req_addr, c_addr);
      chk_eq("mem_req_we", mem_req_we, c_we);
      chk_eq("mem_req_wdata", mem_req_wdata, c_wdata);
      chk_eq("mem_req_wstrb", mem_req_wstrb, c_wstrb);
    end
    chk_eq("mem_rsp_ready", mem_rsp_ready, e_rsp && e_orr);
    chk_eq("ifu_rsp_valid", ifu_rsp_valid, e_rsp && !m_own && mem_rsp_valid);
    chk_eq("ifu_rsp_data", ifu_rsp_data, (e_rsp && !m_own) ? mem_rsp_data : 32'h0);
    chk_eq("lsu_rsp_valid", lsu_rsp_valid, e_rsp && m_own && mem_rsp_valid);
    chk_eq("lsu_rsp_data", lsu_rsp_data, (e_rsp && m_own) ? mem_rsp_data : 32'h0);

    // Advance the model to what the coming posedge does
    m_ifu_acc = 1'b0;
    m_lsu_acc = 1'b0;
    if (rstn) begin
      m_busy = 1'b0; m_issued = 1'b0; m_own = 1'b0; m_starve = 0; s_pend = 1'b0;
    end else if (e_rsp && mem_rsp_valid && e_orr) begin
      m_busy = 1'b0; m_issued = 1'b0; s_pend = 1'b0;
    end else if (e_reqv && mem_req_ready) begin
      m_issued = 1'b1; s_pend = 1'b1; s_data = $urandom;
    end else if (e_ifu_rdy) begin
      m_ifu_acc = 1'b1; m_busy = 1'b1; m_own = 1'b0;
      c_addr = ifu_req_addr; c_we = 1'b0; c_wdata = 32'h0; c_wstrb = 4'h0;
      m_starve = 0;
      if (m_track) chk_eq("starve_run", lsu_run, STARVE_LIMIT);
      lsu_run = 0;
    end else if (e_lsu_rdy) begin
      m_lsu_acc = 1'b1; m_busy = 1'b1; m_own = 1'b1;
      c_addr = lsu_req_addr; c_we = lsu_req_we; c_wdata = lsu_req_wdata; c_wstrb = lsu_req_wstrb;
      if (ifu_req_valid && (m_starve < STARVE_LIMIT)) m_starve++;
      lsu_run++;
    end
  endtask

  int unsigned k_ifu [3] = '{60, 90, 30};
  int unsigned k_lsu [3] = '{60, 90, 80};
  int unsigned k_drop[3] = '{10, 0, 20};
  int unsigned k_mrdy[3] = '{50, 100, 30};
  int unsigned k_rv  [3] = '{50, 100, 40};
  int unsigned k_rr  [3] = '{60, 100, 40};
  int unsigned k_rst [3] = '{5, 0, 3};

  initial begin
    rstn = 1'b1;
    ifu_req_valid = 1'b0; ifu_req_addr = 32'h0; ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b0; lsu_req_addr = 32'h0; lsu_req_we = 1'b0;
    lsu_req_wdata = 32'h0; lsu_req_wstrb = 4'h0; lsu_rsp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    // Junk memory response in idle must be ignored
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAAAA_5555;
    @(negedge clk);
    chk_eq("rst_mem_req_valid", mem_req_valid, 0);
    chk_eq("rst_arb_owner", arb_owner, 0);
    chk_eq("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
    chk_eq("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
    chk_eq("rst_ifu_rsp_data", ifu_rsp_data, 0);
    chk_eq("rst_lsu_rsp_data", lsu_rsp_data, 0);
    chk_eq("rst_mem_req_addr", mem_req_addr, 0);
    chk_eq("rst_mem_req_wdata", mem_req_wdata, 0);
    chk_eq("rst_mem_req_wstrb", mem_req_wstrb, 0);
    chk_eq("rst_mem_rsp_ready", mem_rsp_ready, 0);

    // Single fetch with an immediately ready memory
    tick();
    mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    mem_req_ready = 1'b1; ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
    @(negedge clk);
    chk_eq("d1_ifu_rdy_T", ifu_req_ready, 1);
    chk_eq("d1_lsu_rdy_T", lsu_req_ready, 0);
    tick();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    chk_eq("d1_mreqv_T1", mem_req_valid, 1);
    chk_eq("d1_addr_T1", mem_req_addr, 32'h8000_0000);
    chk_eq("d1_we_T1", mem_req_we, 0);
    chk_eq("d1_owner_T1", arb_owner, 0);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
    @(negedge clk);
    chk_eq("d1_rspv_T2", ifu_rsp_valid, 1);
    chk_eq("d1_rspd_T2", ifu_rsp_data, 32'h13);
    chk_eq("d1_mrspr_T2", mem_rsp_ready, 1);
    chk_eq("d1_lsu_rspv_T2", lsu_rsp_valid, 0);
    chk_eq("d1_mreqv_T2", mem_req_valid, 0);
    tick();
    mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
    @(negedge clk);
    chk_eq("d1_ifu_rdy_T3", ifu_req_ready, 1);
    ifu_req_valid = 1'b0;  // withdrawn before the edge: nothing may be issued

    // Simultaneous IFU fetch and LSU store: LSU wins
    tick();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0008;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h100; lsu_req_we = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'hF; lsu_rsp_ready = 1'b0;
    @(negedge clk);
    chk_eq("d2_no_issue", mem_req_valid, 0);
    chk_eq("d2_lsu_rdy", lsu_req_ready, 1);
    chk_eq("d2_ifu_rdy", ifu_req_ready, 0);
    tick();
    lsu_req_valid = 1'b0;
    @(negedge clk);
    chk_eq("d2_mreqv", mem_req_valid, 1);
    chk_eq("d2_we", mem_req_we, 1);
    chk_eq("d2_addr", mem_req_addr, 32'h100);
    chk_eq("d2_wdata", mem_req_wdata, 32'hDEAD_BEEF);
    chk_eq("d2_wstrb", mem_req_wstrb, 4'hF);
    chk_eq("d2_owner", arb_owner, 1);
    chk_eq("d2_ifu_waits", ifu_req_ready, 0);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0;
    @(negedge clk);
    chk_eq("d2_lsu_rspv", lsu_rsp_valid, 1);
    chk_eq("d2_ifu_rspv", ifu_rsp_valid, 0);
    chk_eq("d2_mrspr_bp", mem_rsp_ready, 0);
    // Reset while the LSU response is back-pressured
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk_eq("d2_hold_rsp", lsu_rsp_valid, 1);
    tick();
    rstn = 1'b0; ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 32'h200;
    lsu_req_wdata = 32'h0; lsu_req_wstrb = 4'h0; lsu_rsp_ready = 1'b1; mem_req_ready = 1'b0;
    @(negedge clk);
    chk_eq("d3_lsu_rspv", lsu_rsp_valid, 0);
    chk_eq("d3_mrspr", mem_rsp_ready, 0);
    chk_eq("d3_mreqv", mem_req_valid, 0);
    chk_eq("d3_owner", arb_owner, 0);
    chk_eq("d3_lsu_rdy", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk_eq("d3_mreqv1", mem_req_valid, 1);
    chk_eq("d3_addr1", mem_req_addr, 32'h200);
    tick();
    @(negedge clk);
    chk_eq("d3_stall_v", mem_req_valid, 1);
    chk_eq("d3_stall_a", mem_req_addr, 32'h200);
    mem_req_ready = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    @(negedge clk);
    chk_eq("d3_rspv", lsu_rsp_valid, 1);
    chk_eq("d3_rspd", lsu_rsp_data, 32'h1234_5678);
    chk_eq("d3_mrspr", mem_rsp_ready, 1);
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);

    // Hand over to the model: idle, LSU owned last, no starvation pending
    m_busy = 1'b0; m_issued = 1'b0; m_own = 1'b1; m_starve = 0;
    m_ifu_acc = 1'b0; m_lsu_acc = 1'b0; s_pend = 1'b0; s_data = 32'h0; lsu_run = 0;
    c_addr = 32'h0; c_we = 1'b0; c_wdata = 32'h0; c_wstrb = 4'h0;

    // Starvation: both requesters always valid, memory never stalls
    p_ifu = 100; p_lsu = 100; p_drop = 0; p_mrdy = 100; p_rv = 100; p_rr = 100; p_rst = 0;
    m_track = 1'b1;
    repeat (40) step();
    m_track = 1'b0;

    // Mixed random traffic with stalls, backpressure, withdrawals and occasional resets
    for (int k = 0; k < 3; k++) begin
      p_ifu = k_ifu[k]; p_lsu = k_lsu[k]; p_drop = k_drop[k];
      p_mrdy = k_mrdy[k]; p_rv = k_rv[k]; p_rr = k_rr[k]; p_rst = k_rst[k];
      repeat (800) step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
